// File: rtl/uart_pkg.sv
// uart_pkg: frame-format encodings shared by the UART transmitter and receiver,
// the receiver state type and small helpers for bit decisions and config decoding.
package uart_pkg;
    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;
    localparam logic [3:0] DATA_NUM_5  = 4'd5;
    localparam logic [3:0] DATA_NUM_6  = 4'd6;
    localparam logic [3:0] DATA_NUM_7  = 4'd7;
    localparam logic [3:0] DATA_NUM_8  = 4'd8;
    localparam logic [1:0] STOP_NUM_1  = 2'b00;
    localparam logic [1:0] STOP_NUM_15 = 2'b01;
    localparam logic [1:0] STOP_NUM_2  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Out-of-range data-bit counts fall back to 8 bits.
    function automatic logic [3:0] data_bits(input logic [3:0] v);
        return (v >= DATA_NUM_5 && v <= DATA_NUM_8) ? v : DATA_NUM_8;
    endfunction
endpackage

// File: rtl/uart_rx_op_if.sv
// uart_rx_op_if: frame configuration and received-character status of the UART receiver.
//   data_bit_num_i/parity_type_i/stop_bit_num_i : frame format from the host
//   data_rx_o/valid_rx_o/parity_err_o/frame_err_o/busy_rx_o : character strobe and status
// master = host side (drives config, consumes characters); slave = receiver.
interface uart_rx_op_if;
    logic [3:0] data_bit_num_i;
    logic [1:0] parity_type_i;
    logic [1:0] stop_bit_num_i;
    logic [7:0] data_rx_o;
    logic       valid_rx_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_rx_o;

    modport master (
        output data_bit_num_i, parity_type_i, stop_bit_num_i,
        input  data_rx_o, valid_rx_o, parity_err_o, frame_err_o, busy_rx_o
    );
    modport slave (
        input  data_bit_num_i, parity_type_i, stop_bit_num_i,
        output data_rx_o, valid_rx_o, parity_err_o, frame_err_o, busy_rx_o
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for an asynchronous input, output resets to 1.
//   clk_i, reset_i (async, active-high) ; d_i asynchronous input ; q_o synchronised output
module uart_rx_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic r_meta;

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) {r_meta, q_o} <= 2'b11;
        else         {r_meta, q_o} <= {d_i, r_meta};
endmodule

// File: rtl/uart_rx_op.sv
// uart_rx_op: UART receive engine with 16x oversampling, majority-of-3 bit decisions,
// runtime frame format and per-character parity/framing status.
//   clk_i, reset_i (async, active-high) ; clk_en_16x_i 16x-baud enable ; uart_rx_i serial line
//   rx_if (slave) : frame config in, received character strobe and status out
// stop_bit_num_i is ignored: only the first stop bit is checked.
module uart_rx_op
    import uart_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clk_en_16x_i,
    input  logic         uart_rx_i,
    uart_rx_op_if.slave  rx_if
);
    logic      w_rx;
    logic      w_bit;
    logic      w_mid;
    rx_state_t r_state;
    logic [3:0] r_tick;
    logic [2:0] r_samp;
    logic [2:0] r_bitcnt;
    logic [3:0] r_nbits;
    logic [1:0] r_ptype;
    logic [7:0] r_data;
    logic       r_perr;

    uart_rx_sync u_sync (.clk_i(clk_i), .reset_i(reset_i), .d_i(uart_rx_i), .q_o(w_rx));

    // Full-bit decisions use the three stored samples; the stop bit is decided at
    // tick 9, so its third sample is the live line.
    assign w_bit = maj3(r_samp[2], r_samp[1], r_samp[0]);
    assign w_mid = maj3(r_samp[1], r_samp[0], w_rx);

    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            r_state            <= ST_IDLE;
            r_tick             <= 4'd0;
            r_samp             <= 3'b111;
            r_bitcnt           <= 3'd0;
            r_nbits            <= DATA_NUM_8;
            r_ptype            <= PARITY_NONE;
            r_data             <= 8'd0;
            r_perr             <= 1'b0;
            rx_if.data_rx_o    <= 8'd0;
            rx_if.valid_rx_o   <= 1'b0;
            rx_if.parity_err_o <= 1'b0;
            rx_if.frame_err_o  <= 1'b0;
            rx_if.busy_rx_o    <= 1'b0;
        end else begin
            rx_if.valid_rx_o <= 1'b0;
            if (clk_en_16x_i) begin
                r_tick <= r_tick + 4'd1;
                if (r_tick inside {4'd7, 4'd8, 4'd9}) r_samp <= {r_samp[1:0], w_rx};
                case (r_state)
                    ST_IDLE:
                        if (!w_rx) begin
                            r_state         <= ST_START;
                            r_tick          <= 4'd0;
                            r_nbits         <= data_bits(rx_if.data_bit_num_i);
                            r_ptype         <= rx_if.parity_type_i;
                            r_perr          <= 1'b0;
                            rx_if.busy_rx_o <= 1'b1;
                        end
                    ST_START:
                        if (r_tick == 4'd15) begin
                            r_state         <= w_bit ? ST_IDLE : ST_DATA;
                            rx_if.busy_rx_o <= ~w_bit;
                            r_bitcnt        <= 3'd0;
                            r_data          <= 8'd0;
                        end
                    ST_DATA:
                        if (r_tick == 4'd15) begin
                            r_data[r_bitcnt] <= w_bit;
                            r_bitcnt         <= r_bitcnt + 3'd1;
                            if ({1'b0, r_bitcnt} == r_nbits - 4'd1)
                                r_state <= (r_ptype == PARITY_EVEN || r_ptype == PARITY_ODD) ? ST_PARITY : ST_STOP;
                        end
                    ST_PARITY:
                        if (r_tick == 4'd15) begin
                            r_perr  <= w_bit != ((r_ptype == PARITY_ODD) ? ~^r_data : ^r_data);
                            r_state <= ST_STOP;
                        end
                    ST_STOP:
                        if (r_tick == 4'd9) begin
                            rx_if.data_rx_o    <= r_data;
                            rx_if.parity_err_o <= r_perr;
                            rx_if.frame_err_o  <= ~w_mid;
                            rx_if.valid_rx_o   <= 1'b1;
                            rx_if.busy_rx_o    <= ~w_mid;
                            r_state            <= w_mid ? ST_IDLE : ST_BREAK;
                        end
                    ST_BREAK:
                        if (w_rx) begin
                            r_state         <= ST_IDLE;
                            rx_if.busy_rx_o <= 1'b0;
                        end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
endmodule

// File: tb/tb_uart_rx_op.sv
// tb_uart_rx_op: scoreboard bench for uart_rx_op driving serial frames from a bit-level model.
module tb_uart_rx_op;
    import uart_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic line = 1'b1;
    int en_div = 2;
    int en_cnt = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;
    exp_t sb_q[$];

    uart_rx_op_if rx_if();

    uart_rx_op dut (
        .clk_i(clk),
        .reset_i(rst),
        .clk_en_16x_i(en),
        .uart_rx_i(line),
        .rx_if(rx_if)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        en_cnt = (en_cnt + 1 >= en_div) ? 0 : en_cnt + 1;
        en = (en_cnt == 0);
    end

    always @(negedge clk)
        if (rx_if.valid_rx_o) begin
            exp_t e;
            n_strobe++;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: got data %h with nothing expected", rx_if.data_rx_o);
            end else begin
                e = sb_q.pop_front();
                if (rx_if.data_rx_o !== e.d) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", rx_if.data_rx_o, e.d);
                end
                n_cmp++;
                if (rx_if.parity_err_o !== e.pe) begin
                    n_err++;
                    $display("FAIL sb_parity_err: got %b expected %b (data %h)", rx_if.parity_err_o, e.pe, e.d);
                end
                n_cmp++;
                if (rx_if.frame_err_o !== e.fe) begin
                    n_err++;
                    $display("FAIL sb_frame_err: got %b expected %b (data %h)", rx_if.frame_err_o, e.fe, e.d);
                end
            end
        end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        repeat (n * en_div) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        line = b;
        if (glitch) begin
            wait_ticks(8);
            line = ~b;
            wait_ticks(1);
            line = b;
            wait_ticks(7);
        end else wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic [1:0] pt, input int nstop,
                              input logic flip_par, input logic stop_lvl, input int glitch_bit, input logic push);
        logic [7:0] dm;
        logic p;
        dm = d & 8'((1 << nb) - 1);
        p = (pt == PARITY_ODD) ? ~^dm : ^dm;
        rx_if.data_bit_num_i = 4'(nb);
        rx_if.parity_type_i = pt;
        rx_if.stop_bit_num_i = (nstop == 2) ? STOP_NUM_2 : STOP_NUM_1;
        if (push) sb_q.push_back('{d: dm, pe: flip_par, fe: ~stop_lvl});
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) drive_bit(dm[i], i == glitch_bit);
        if (pt == PARITY_EVEN || pt == PARITY_ODD) drive_bit(p ^ flip_par, 1'b0);
        drive_bit(stop_lvl, 1'b0);
        if (nstop == 2) drive_bit(1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 * en_div && sb_q.size() != 0; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line = 1'b1;
        rx_if.data_bit_num_i = DATA_NUM_8;
        rx_if.parity_type_i = PARITY_NONE;
        rx_if.stop_bit_num_i = STOP_NUM_1;
        repeat (4) @(negedge clk);
        n_cmp++; if (rx_if.data_rx_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", rx_if.data_rx_o); end
        n_cmp++; if (rx_if.valid_rx_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", rx_if.valid_rx_o); end
        n_cmp++; if (rx_if.parity_err_o !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %b expected 0", rx_if.parity_err_o); end
        n_cmp++; if (rx_if.frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b expected 0", rx_if.frame_err_o); end
        n_cmp++; if (rx_if.busy_rx_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", rx_if.busy_rx_o); end
        rst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_8n1();
        int s0 = n_strobe;
        send_frame(8'hA5, 8, PARITY_NONE, 1, 1'b0, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL 8n1_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
        n_cmp++; if (n_strobe - s0 != 1) begin n_err++; $display("FAIL 8n1_strobes: got %0d expected 1", n_strobe - s0); end
        n_cmp++; if (rx_if.busy_rx_o !== 1'b0) begin n_err++; $display("FAIL 8n1_busy: got %b expected 0", rx_if.busy_rx_o); end
    endtask

    task automatic test_7e1();
        int s0 = n_strobe;
        send_frame(8'h35, 7, PARITY_EVEN, 1, 1'b0, 1'b1, -1, 1'b1);
        send_frame(8'h35, 7, PARITY_EVEN, 1, 1'b1, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL 7e1_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
        n_cmp++; if (n_strobe - s0 != 2) begin n_err++; $display("FAIL 7e1_strobes: got %0d expected 2", n_strobe - s0); end
        n_cmp++; if (rx_if.parity_err_o !== 1'b1) begin n_err++; $display("FAIL 7e1_perr_hold: got %b expected 1", rx_if.parity_err_o); end
    endtask

    task automatic test_5o2();
        send_frame(8'h1F, 5, PARITY_ODD, 2, 1'b0, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL 5o2_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_loopback();
        int s0 = n_strobe;
        en_div = 1;
        for (int v = 0; v < 256; v++) send_frame(8'(v), 8, PARITY_ODD, 1, 1'b0, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL loop_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
        n_cmp++; if (n_strobe - s0 != 256) begin n_err++; $display("FAIL loop_strobes: got %0d expected 256", n_strobe - s0); end
        en_div = 2;
        wait_ticks(4);
    endtask

    task automatic test_break();
        int s0 = n_strobe;
        send_frame(8'h00, 8, PARITY_NONE, 1, 1'b0, 1'b0, -1, 1'b1);
        wait_ticks(3 * 10 * 16);
        n_cmp++; if (n_strobe - s0 != 1) begin n_err++; $display("FAIL break_strobes: got %0d expected 1", n_strobe - s0); end
        n_cmp++; if (rx_if.busy_rx_o !== 1'b1) begin n_err++; $display("FAIL break_busy: got %b expected 1", rx_if.busy_rx_o); end
        n_cmp++; if (rx_if.frame_err_o !== 1'b1) begin n_err++; $display("FAIL break_ferr_hold: got %b expected 1", rx_if.frame_err_o); end
        line = 1'b1;
        wait_ticks(32);
        n_cmp++; if (rx_if.busy_rx_o !== 1'b0) begin n_err++; $display("FAIL break_release_busy: got %b expected 0", rx_if.busy_rx_o); end
        n_cmp++; if (n_strobe - s0 != 1) begin n_err++; $display("FAIL break_release_strobes: got %0d expected 1", n_strobe - s0); end
        send_frame(8'h55, 8, PARITY_NONE, 1, 1'b0, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL break_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_glitch();
        int s0 = n_strobe;
        line = 1'b0;
        wait_ticks(4);
        line = 1'b1;
        wait_ticks(2);
        n_cmp++; if (rx_if.busy_rx_o !== 1'b1) begin n_err++; $display("FAIL glitch_busy_rise: got %b expected 1", rx_if.busy_rx_o); end
        wait_ticks(14);
        n_cmp++; if (rx_if.busy_rx_o !== 1'b0) begin n_err++; $display("FAIL glitch_busy_fall: got %b expected 0", rx_if.busy_rx_o); end
        n_cmp++; if (n_strobe != s0) begin n_err++; $display("FAIL glitch_strobes: got %0d expected 0", n_strobe - s0); end
        wait_ticks(16);
        send_frame(8'h96, 8, PARITY_NONE, 1, 1'b0, 1'b1, 1, 1'b1);
        send_frame(8'h96, 8, PARITY_EVEN, 1, 1'b0, 1'b1, 6, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL glitch_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    endtask

    task automatic test_reset_mid();
        int s0 = n_strobe;
        logic [7:0] d = 8'hC3;
        rx_if.data_bit_num_i = DATA_NUM_8;
        rx_if.parity_type_i = PARITY_NONE;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i], 1'b0);
        line = d[3];
        wait_ticks(8);
        n_cmp++; if (rx_if.busy_rx_o !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before: got %b expected 1", rx_if.busy_rx_o); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx_if.data_rx_o !== 8'h00) begin n_err++; $display("FAIL rmid_data: got %h expected 00", rx_if.data_rx_o); end
        n_cmp++; if (rx_if.busy_rx_o !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b expected 0", rx_if.busy_rx_o); end
        n_cmp++; if (rx_if.parity_err_o !== 1'b0) begin n_err++; $display("FAIL rmid_perr: got %b expected 0", rx_if.parity_err_o); end
        n_cmp++; if (rx_if.valid_rx_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", rx_if.valid_rx_o); end
        wait_ticks(2);
        line = 1'b1;
        rst = 1'b0;
        wait_ticks(32);
        n_cmp++; if (n_strobe != s0) begin n_err++; $display("FAIL rmid_strobes: got %0d expected 0", n_strobe - s0); end
        send_frame(8'h3C, 8, PARITY_NONE, 1, 1'b0, 1'b1, -1, 1'b1);
        drain();
        n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL rmid_pending: got %0d left expected 0", sb_q.size()); sb_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_5o2();
        test_loopback();
        test_break();
        test_glitch();
        test_reset_mid();
        wait_ticks(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_op.md
# uart_rx_op

UART receive engine: the downstream counterpart of the UART transmitter. It deserialises the serial line using a 16x-baud oversampling enable and presents each received character as a one-cycle strobe with parity and framing status. Its frame format inputs use the same encodings as the transmitter, so a TX→RX loopback runs with shared configuration.

## Interface
Parameters:
- none. Frame format is runtime-configured through ports.

Ports:
- `clk_i` in 1: system clock.
- `reset_i` in 1: reset, asynchronous, active-high.
- `clk_en_16x_i` in 1: one-cycle enable pulse at 16× baud rate (115200×16 nominal).
- `data_bit_num_i` in 4: data bits, 5/6/7/8; any other value is treated as 8.
- `parity_type_i` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop_bit_num_i` in 2: 00 one, 01 one-and-half, 10 two. Accepted for symmetry with TX; the receiver checks the first stop bit only.
- `uart_rx_i` in 1: asynchronous serial input, idle high.
- `data_rx_o` out 8: received character, LSB-aligned; unused upper bits are 0.
- `valid_rx_o` out 1: one-cycle strobe, character complete.
- `parity_err_o` out 1: parity mismatch for the character strobed.
- `frame_err_o` out 1: stop bit sampled low for the character strobed.
- `busy_rx_o` out 1: frame in progress, from start detection to return to IDLE.

## Operation
- Input path: 2-flop synchroniser on `uart_rx_i`. Both flops reset to 1. All decisions use the synchronised line.
- Tick counter: 4 bits. It advances only on `clk_en_16x_i`, wraps 15→0, and clears on entry to START.
- Bit decision: majority of 3 samples, taken at tick counts 7, 8 and 9.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START: the synchronised line is 0 on an enable tick.
  - On this transition, latch `data_bit_num_i` and `parity_type_i`. Config changes mid-frame have no effect.
- START: at tick 15, the majority result decides the next state.
  - Majority 1 (false start): go to IDLE. No strobe, no error.
  - Majority 0: go to DATA, with the bit counter cleared.
- DATA: at each tick 15, shift the majority bit in LSB-first and increment the bit counter.
  - After the latched number of bits, go to PARITY if parity is enabled, else STOP.
- PARITY: compare the majority bit with the expected parity.
  - Even: expected = ^data.
  - Odd: expected = ~^data.
  - Mismatch sets the parity error for this character.
- STOP: decide at tick 9, i.e. mid-bit, to allow early resync to the next start bit.
  - Update `data_rx_o`, `parity_err_o`, `frame_err_o` and pulse `valid_rx_o`.
  - Stop majority 1: go to IDLE.
  - Stop majority 0: set `frame_err_o` and go to BREAK.
- BREAK: wait until the synchronised line reads 1 on an enable tick, then go to IDLE. No start detection while in BREAK.
- `data_rx_o`, `parity_err_o` and `frame_err_o` hold their values until the next strobe. There is no FIFO; the consumer must accept each character within one character time.
- A character with an error is still strobed, with its data.

## Timing
- Reset values:
  - state IDLE, synchroniser 1.
  - `data_rx_o` = 0.
  - `valid_rx_o`, `parity_err_o`, `frame_err_o`, `busy_rx_o` = 0.
- Reset mid-frame returns to IDLE immediately and clears all outputs. The next falling edge starts a fresh frame.
- Synchroniser latency: 2 clk.
- Strobe timing: `valid_rx_o` rises 1 clk after the stop-bit tick-9 enable, i.e. registered, and lasts exactly 1 clk.
- 8N1 frame: the strobe occurs about 9.56 bit times after the start edge, plus 3 clk.
- `busy_rx_o`:
  - rises 1 clk after the IDLE→START transition;
  - falls together with the `valid_rx_o` strobe, or on the BREAK→IDLE transition;
  - also falls on a false-start return to IDLE.
- Simultaneous start edge and strobe: a new start edge seen in the same cycle as the STOP decision is ignored. Detection resumes from IDLE on the next enable tick.
- Tolerance: ±3% baud mismatch is received without error.

## Structure
- Shared package `uart_pkg` holds constants used by both TX and RX:
  - PARITY_NONE/EVEN/ODD;
  - DATA_NUM_5..8;
  - STOP_NUM_1/15/2.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with reset-to-1 output. Reusable for other asynchronous inputs.

## Test plan
- 8N1, 0xA5 at 16× enable: exactly one `valid_rx_o`, `data_rx_o`=0xA5, both errors 0, `busy_rx_o` low afterwards.
- 7E1, 0x35 (parity bit 0), then 0x35 with parity bit forced to 1: `data_rx_o`=0x35 both times; `parity_err_o` 0 then 1.
- 5O2, 0x1F: `data_rx_o`=0x1F, `parity_err_o`=0. Also, TX→RX loopback of 0x00..0xFF in 8O1 receives all 256 values correctly.
- Stop bit forced 0 with data 0x00 and the line held low for 3 frames (break): one strobe with `frame_err_o`=1, then no further strobes until the line returns high. The next 0x55 frame is received correctly.
- 4-tick low glitch on an idle line: no strobe, `busy_rx_o` returns to 0 within 16 ticks. Single-sample glitch at tick 8 inside a data bit: bit value unaffected by majority.
- Assert `reset_i` during DATA bit 3 of 0xC3: outputs clear immediately and no strobe occurs. A following 0x3C frame is received correctly.
